ex_mem_skid: RTL and testbench

EX_MEM_SKID -- requirements
Module: ex_mem_skid

---
 rtl/ex_mem_skid_pkg.sv | 23 ++
 rtl/ex_mem_skid_entry.sv | 30 +++
 rtl/ex_mem_skid.sv | 145 ++++++++++++++
 tb/tb_ex_mem_skid.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_skid_pkg
// Description : Shared state encoding and constants for the EX/MEM skid stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_skid_pkg;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    // Register address 0 is the architectural NOP destination.
    localparam int unsigned c_nop_wd    = 0;
    localparam int unsigned c_zero_word = 0;

    // Packed payload: {wd, wreg, wdata, hi, lo, whilo}.
    function automatic int unsigned bundle_width(input int unsigned aw, input int unsigned dw);
        return aw + 3 * dw + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_skid_entry.sv
`default_nettype none
// ============================================================================
// Module      : skid_entry
// Description : Payload register with load enable and async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_skid.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_skid
// Description : Two-entry EX/MEM pipeline skid buffer with registered ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [AW-1:0] ex_wd,
    input  logic          ex_wreg,
    input  logic [DW-1:0] ex_wdata,
    input  logic [DW-1:0] ex_hi,
    input  logic [DW-1:0] ex_lo,
    input  logic          ex_whilo,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_wd,
    output logic          mem_wreg,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_hi,
    output logic [DW-1:0] mem_lo,
    output logic          mem_whilo,
    output logic [CW-1:0] stall_cnt
);

    localparam int BW = int'(bundle_width(AW, DW));

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_ex_ready;
    logic          w_in;
    logic          w_out;
    logic          w_mem_valid;
    logic          w_main_load;
    logic          w_skid_load;
    logic          w_main_from_skid;
    logic [BW-1:0] w_ex_bundle;
    logic [BW-1:0] w_main_d;
    logic [BW-1:0] w_main_q;
    logic [BW-1:0] w_skid_q;
    logic [BW-1:0] w_idle_bundle;
    logic [BW-1:0] w_mem_bundle;
    logic [CW-1:0] r_stall_cnt;

    assign w_ex_bundle = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo};
    assign w_mem_valid = (r_state != c_st_empty);
    assign w_in        = ex_valid & r_ex_ready;
    assign w_out       = w_mem_valid & mem_ready;

    // Ready is registered from the next state so it never sees mem_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_st_empty;
            r_ex_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_ex_ready <= (w_state_next != c_st_full);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = c_st_empty;
        end else begin
            case (r_state)
                c_st_empty: if (w_in) w_state_next = c_st_one;
                c_st_one: begin
                    if (w_in && !w_out)      w_state_next = c_st_full;
                    else if (!w_in && w_out) w_state_next = c_st_empty;
                end
                c_st_full:  if (w_out) w_state_next = c_st_one;
                default:    w_state_next = c_st_empty;
            endcase
        end
    end

    always_comb begin
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        if (!flush) begin
            case (r_state)
                c_st_empty: w_main_load = w_in;
                c_st_one: begin
                    w_main_load = w_in & w_out;
                    w_skid_load = w_in & ~w_out;
                end
                c_st_full: begin
                    w_main_load      = w_out;
                    w_main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_ex_bundle;

    skid_entry #(.W(BW)) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    skid_entry #(.W(BW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_d    (w_ex_bundle),
        .o_q    (w_skid_q)
    );

    assign w_idle_bundle = {AW'(c_nop_wd), 1'b0, DW'(c_zero_word), DW'(c_zero_word),
                            DW'(c_zero_word), 1'b0};
    assign w_mem_bundle  = w_mem_valid ? w_main_q : w_idle_bundle;

    assign {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo} = w_mem_bundle;
    assign mem_valid = w_mem_valid;
    assign ex_ready  = r_ex_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_mem_valid && !mem_ready && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_skid
// Description : Scoreboard bench for ex_mem_skid (main DUT plus a CW=4 copy).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = AW + 3 * DW + 2;

    typedef logic [PW-1:0] pay_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          ex_valid = 1'b0;
    logic [AW-1:0] ex_wd = '0;
    logic          ex_wreg = 1'b0;
    logic [DW-1:0] ex_wdata = '0;
    logic [DW-1:0] ex_hi = '0;
    logic [DW-1:0] ex_lo = '0;
    logic          ex_whilo = 1'b0;
    logic          mem_ready = 1'b0;

    logic          ex_ready, mem_valid, mem_wreg, mem_whilo;
    logic [AW-1:0] mem_wd;
    logic [DW-1:0] mem_wdata, mem_hi, mem_lo;
    logic [15:0]   stall_cnt;

    logic          ex_ready4, mem_valid4, mem_wreg4, mem_whilo4;
    logic [AW-1:0] mem_wd4;
    logic [DW-1:0] mem_wdata4, mem_hi4, mem_lo4;
    logic [3:0]    stall_cnt4;

    pay_t mem_pay;
    pay_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    assign mem_pay = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};

    ex_mem_skid #(.DW(DW), .AW(AW), .CW(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .stall_cnt(stall_cnt)
    );

    ex_mem_skid #(.DW(DW), .AW(AW), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready4),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .mem_valid(mem_valid4), .mem_ready(mem_ready),
        .mem_wd(mem_wd4), .mem_wreg(mem_wreg4), .mem_wdata(mem_wdata4),
        .mem_hi(mem_hi4), .mem_lo(mem_lo4), .mem_whilo(mem_whilo4),
        .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic pay_t mk(input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] d,
                                input logic [DW-1:0] h, input logic [DW-1:0] l, input logic wh);
        return {wd, wreg, d, h, l, wh};
    endfunction

    // Monitor: every consumed output must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst) begin
            if (flush) begin
                q.delete();
            end else if (mem_valid && mem_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %h expected nothing", mem_pay);
                end else begin
                    pay_t e;
                    e = q.pop_front();
                    check("out_payload", 128'(mem_pay), 128'(e));
                end
            end
            if (!mem_valid) check("idle_zero", 128'(mem_pay), 128'd0);
        end
    end

    task automatic do_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        ex_valid  = 1'b0;
        mem_ready = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send(input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] d,
                        input logic [DW-1:0] h, input logic [DW-1:0] l, input logic wh);
        bit ok;
        ok       = 1'b0;
        ex_wd    = wd;
        ex_wreg  = wreg;
        ex_wdata = d;
        ex_hi    = h;
        ex_lo    = l;
        ex_whilo = wh;
        ex_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ex_ready) begin
                q.push_back(mk(wd, wreg, d, h, l, wh));
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no ready expected ready within 50 cycles");
        end
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    task automatic drain();
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("drain_empty", 128'(q.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit got;

        // Reset holds everything at zero even with a valid offer present.
        rst = 1'b0; mem_ready = 1'b1;
        ex_valid = 1'b1; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234;
        repeat (3) @(negedge clk);
        check("rst_mem_valid", 128'(mem_valid), 128'd0);
        check("rst_ex_ready", 128'(ex_ready), 128'd1);
        check("rst_mem_zero", 128'(mem_pay), 128'd0);
        check("rst_stall", 128'(stall_cnt), 128'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 128'(ex_ready), 128'd1);
        q.push_back(mk(5'd3, 1'b1, 32'h1234, '0, '0, 1'b0));
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(negedge clk);
        check("latency_valid", 128'(mem_valid), 128'd1);
        check("latency_data", 128'(mem_wdata), 128'h1234);
        drain();

        // Streaming at full rate.
        do_reset();
        mem_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            ex_valid = 1'b1; ex_wd = AW'(i); ex_wreg = 1'b1; ex_wdata = DW'(i);
            ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0;
            @(negedge clk);
            check("stream_ready", 128'(ex_ready), 128'd1);
            q.push_back(mk(AW'(i), 1'b1, DW'(i), '0, '0, 1'b0));
            if (i > 1) check("stream_rate", 128'(mem_wdata), 128'(i - 1));
            @(posedge clk);
            #1;
        end
        ex_valid = 1'b0;
        @(negedge clk);
        check("stream_last", 128'(mem_wdata), 128'hA);
        drain();

        // Back-pressure fills both entries, third word waits at EX.
        do_reset();
        send(5'd1, 1'b1, 32'hA, '0, '0, 1'b0);
        send(5'd2, 1'b1, 32'hB, '0, '0, 1'b0);
        ex_valid = 1'b1; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'hC;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 128'(ex_ready), 128'd0);
            check("bp_stall", 128'(stall_cnt), 128'(k + 1));
            check("bp_hold", 128'(mem_wdata), 128'hA);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ex_ready) begin
                q.push_back(mk(5'd3, 1'b1, 32'hC, '0, '0, 1'b0));
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("bp_c_accepted", 128'(got), 128'd1);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        check("bp_stall_final", 128'(stall_cnt), 128'd4);
        drain();

        // Flush while full squashes both entries and the incoming word.
        do_reset();
        send(5'd1, 1'b1, 32'h1, '0, '0, 1'b0);
        send(5'd2, 1'b1, 32'h2, '0, '0, 1'b0);
        ex_valid = 1'b1; ex_wd = 5'd4; ex_wreg = 1'b1; ex_wdata = 32'hD;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 128'(mem_valid), 128'd0);
        check("flush_wreg", 128'(mem_wreg), 128'd0);
        check("flush_ready", 128'(ex_ready), 128'd1);
        check("flush_stall", 128'(stall_cnt), 128'd2);
        drain();

        // Asynchronous reset between edges clears the entries immediately.
        do_reset();
        send(5'd1, 1'b1, 32'h11, '0, '0, 1'b0);
        send(5'd2, 1'b1, 32'h22, '0, '0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_valid", 128'(mem_valid), 128'd0);
        check("async_ready", 128'(ex_ready), 128'd1);
        check("async_zero", 128'(mem_pay), 128'd0);
        q.delete();
        #1 rst = 1'b1;
        drain();

        // HI/LO write with the GPR write disabled still occupies an entry.
        do_reset();
        mem_ready = 1'b1;
        send(5'd7, 1'b0, 32'h77, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
        drain();
        do_reset();
        send(5'd7, 1'b0, 32'h77, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
        @(negedge clk);
        check("hilo_whilo", 128'(mem_whilo), 128'd1);
        check("hilo_wreg", 128'(mem_wreg), 128'd0);
        check("hilo_hi", 128'(mem_hi), 128'hFFFF0000);
        check("hilo_lo", 128'(mem_lo), 128'h0000FFFF);
        drain();

        // Stall counter saturation on the CW=4 copy.
        do_reset();
        send(5'd1, 1'b1, 32'h5, '0, '0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("sat_cw16", 128'(stall_cnt), 128'd20);
        check("sat_cw4", 128'(stall_cnt4), 128'd15);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
